// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single uart_tx between N_REQ byte-stream requesters. Ownership is
// granted round-robin per message: the winner keeps the UART until it hands
// over a byte flagged last. Each byte is sent with a one-cycle start pulse on
// tx_e_o, and the next byte is only loaded once uart_tx busy has risen and
// fallen again, so at most one byte is ever in flight.
//
// Optional feature (macro UART_ARB_ID_PREFIX_EN): every message on the wire
// is preceded by a source ID byte ID_BASE + requester index.
//
// Ports
//   clk          clock
//   resetn       synchronous, active-low reset (shared with uart_tx)
//   req_valid_i  [N_REQ]    requester i presents a byte
//   req_data_i   [8*N_REQ]  lane i = bits [8*i+7:8*i]
//   req_last_i   [N_REQ]    byte on lane i ends its message
//   req_ready_o  [N_REQ]    byte on lane i accepted when valid & ready
//   grant_o      [N_REQ]    one-hot owner of the UART, 0 when free
//   tx_e_o                  start pulse to uart_tx e_i
//   tx_d_o       [8]        byte to uart_tx d_i, held for the whole byte
//   tx_busy_i               uart_tx busy_o
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int         N_REQ   = 4,
    parameter logic [7:0] ID_BASE = 8'h80
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               tx_e_o,
    output logic [7:0]         tx_d_o,
    input  logic               tx_busy_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // The prefix value must not wrap past 8'hFF for any requester.
    if (N_REQ < 2 || N_REQ > 8 || (int'(ID_BASE) + N_REQ - 1) > 255) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and ID_BASE+N_REQ-1 must fit in 8 bits");
    end

`ifdef UART_ARB_ID_PREFIX_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_PREFIX  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         tx_d_q, tx_d_d;
    logic               last_q, last_d;
`ifdef UART_ARB_ID_PREFIX_EN
    logic [IDX_W-1:0]   win_q, win_d;
`endif

    // Round-robin search: first valid index at or after ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] pick_winner(input logic [N_REQ-1:0] vld,
                                                   input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && vld[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

    logic [IDX_W:0]   pick;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             accept;

    always_comb begin
        pick       = pick_winner(req_valid_i, rr_ptr_q);
        pick_found = pick[IDX_W];
        pick_idx   = pick[IDX_W-1:0];
    end

    // Lane of the current owner; grant_q is one-hot so at most one lane matches.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data = req_data_i[8*i +: 8];
                sel_last = req_last_i[i];
            end
        end
    end

    // Ready is combinational from the registered grant, only while loading.
    assign req_ready_o = (state_q == S_LOAD) ? (grant_q & req_valid_i) : '0;
    assign accept      = (state_q == S_LOAD) && (|(grant_q & req_valid_i));
    assign tx_e_o      = (state_q == S_SEND) && !tx_busy_i;
    assign tx_d_o      = tx_d_q;
    assign grant_o     = grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        tx_d_d   = tx_d_q;
        last_d   = last_q;
`ifdef UART_ARB_ID_PREFIX_EN
        win_d    = win_q;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    rr_ptr_d = IDX_W'((int'(pick_idx) + 1) % N_REQ);
`ifdef UART_ARB_ID_PREFIX_EN
                    win_d    = pick_idx;
                    state_d  = S_PREFIX;
`else
                    state_d  = S_LOAD;
`endif
                end
            end
`ifdef UART_ARB_ID_PREFIX_EN
            // Source ID byte goes out first; last_q=0 brings us back to LOAD.
            S_PREFIX: begin
                tx_d_d  = ID_BASE + 8'(win_q);
                last_d  = 1'b0;
                state_d = S_SEND;
            end
`endif
            S_LOAD: begin
                if (accept) begin
                    tx_d_d  = sel_data;
                    last_d  = sel_last;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy_i) begin
                    state_d = S_WAIT_HI;
                end
            end
            // uart_tx may take any number of cycles to raise busy.
            S_WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy_i) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            tx_d_q   <= '0;
            last_q   <= 1'b0;
`ifdef UART_ARB_ID_PREFIX_EN
            win_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            tx_d_q   <= tx_d_d;
            last_q   <= last_d;
`ifdef UART_ARB_ID_PREFIX_EN
            win_q    <= win_d;
`endif
        end
    end

endmodule
